// File: rtl/mc_sequencer_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package mc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_HALT, ST_ERR
    } state_e;

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_NONE  = 2'b00;

    function automatic logic is_busy(input state_e s);
        return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC) || (s == ST_WB);
    endfunction

endpackage

// File: rtl/mc_pc_reg.sv
// Program counter: loads RESET_PC on reset, steps by PC_STEP (mod 2^32) on inc_i.
module mc_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (inc_i) pc_d = pc_q + 32'(PC_STEP);
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer with registered strobes and status.
// Optional retired-instruction counter enabled by MC_SEQUENCER_PERF_CNT_EN.
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4,
    parameter logic [5:0]  HALT_OP  = 6'h3F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        im_ready,
    input  logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic        im_req,
    output logic        ir_load,
    output logic        alu_en,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] retired_cnt
);

    state_e     state_q, state_d;
    logic       im_req_q, im_req_d;
    logic       ir_load_q, ir_load_d;
    logic       alu_en_q, alu_en_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic       reg_write_q, reg_write_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            im_req_q    <= 1'b0;
            ir_load_q   <= 1'b0;
            alu_en_q    <= 1'b0;
            alu_op_q    <= ALUOP_NONE;
            reg_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            im_req_q    <= im_req_d;
            ir_load_q   <= ir_load_d;
            alu_en_q    <= alu_en_d;
            alu_op_q    <= alu_op_d;
            reg_write_q <= reg_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH:  if (im_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (opcode == OP_RTYPE)     state_d = ST_EXEC;
                else if (opcode == HALT_OP) state_d = ST_HALT;
                else                        state_d = ST_ERR;
            end
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            ST_ERR:    state_d = ST_ERR;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Status and im_req track the state they describe; the one-cycle strobes are
    // registered from the state (and im_ready) that triggers them, so each lands
    // on the cycle after its trigger and reset on that edge cancels it.
    always_comb begin
        im_req_d    = (state_d == ST_FETCH);
        busy_d      = is_busy(state_d);
        done_d      = (state_d == ST_HALT);
        err_d       = (state_d == ST_ERR);
        ir_load_d   = (state_q == ST_FETCH) && im_ready;
        alu_en_d    = (state_q == ST_EXEC);
        alu_op_d    = alu_en_d ? ALUOP_RTYPE : ALUOP_NONE;
        reg_write_d = (state_q == ST_WB);
    end

    mc_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk   (clk),
        .rst   (rst),
        .inc_i (state_q == ST_WB),
        .pc_o  (pc)
    );

`ifdef MC_SEQUENCER_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ST_WB) && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 32'h0;
        else     cnt_q <= cnt_d;
    end

    assign retired_cnt = cnt_q;
`else
    assign retired_cnt = 32'h0;
`endif

    assign im_req    = im_req_q;
    assign ir_load   = ir_load_q;
    assign alu_en    = alu_en_q;
    assign alu_op    = alu_op_q;
    assign reg_write = reg_write_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: instance a uses RESET_PC=0, instance b uses
// RESET_PC=FFFF_FFFC to exercise pc wrap; both share the same stimulus.
module tb_mc_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, im_ready;
    logic [5:0]  opcode;

    logic [31:0] a_pc, a_cnt, b_pc, b_cnt;
    logic        a_im_req, a_ir_load, a_alu_en, a_reg_write, a_busy, a_done, a_err;
    logic        b_im_req, b_ir_load, b_alu_en, b_reg_write, b_busy, b_done, b_err;
    logic [1:0]  a_alu_op, b_alu_op;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef MC_SEQUENCER_PERF_CNT_EN
    localparam logic [31:0] RET2 = 32'd2;
`else
    localparam logic [31:0] RET2 = 32'd0;
`endif

    always #5 clk = ~clk;

    mc_sequencer #(.RESET_PC(32'h0000_0000)) u_a (
        .clk(clk), .rst(rst), .start(start), .im_ready(im_ready), .opcode(opcode),
        .pc(a_pc), .im_req(a_im_req), .ir_load(a_ir_load), .alu_en(a_alu_en),
        .alu_op(a_alu_op), .reg_write(a_reg_write), .busy(a_busy), .done(a_done),
        .err(a_err), .retired_cnt(a_cnt)
    );

    mc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_b (
        .clk(clk), .rst(rst), .start(start), .im_ready(im_ready), .opcode(opcode),
        .pc(b_pc), .im_req(b_im_req), .ir_load(b_ir_load), .alu_en(b_alu_en),
        .alu_op(b_alu_op), .reg_write(b_reg_write), .busy(b_busy), .done(b_done),
        .err(b_err), .retired_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        rst = 1'b1; start = 1'b0; im_ready = 1'b1; opcode = 6'h00;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Reset state and two R-format instructions then HALT
        do_rst();
        chk("rst_pc_a", a_pc, 32'h0);
        chk("rst_pc_b", b_pc, 32'hFFFF_FFFC);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_im_req", 32'(a_im_req), 32'd0);
        chk("rst_done_err", {30'd0, a_done, a_err}, 32'd0);
        chk("rst_cnt", a_cnt, 32'h0);

        start = 1'b1; tick(); start = 1'b0;
        chk("f_im_req", 32'(a_im_req), 32'd1);
        chk("f_busy", 32'(a_busy), 32'd1);
        chk("f_ir_load", 32'(a_ir_load), 32'd0);
        tick();
        chk("c1_ir_load", 32'(a_ir_load), 32'd1);
        chk("c1_im_req", 32'(a_im_req), 32'd0);
        tick();
        chk("c2_ir_load", 32'(a_ir_load), 32'd0);
        chk("c2_alu_en", 32'(a_alu_en), 32'd0);
        tick();
        chk("c3_alu_en", 32'(a_alu_en), 32'd1);
        chk("c3_alu_op", 32'(a_alu_op), 32'd2);
        chk("c3_reg_write", 32'(a_reg_write), 32'd0);
        tick();
        chk("c4_reg_write", 32'(a_reg_write), 32'd1);
        chk("c4_alu_en", 32'(a_alu_en), 32'd0);
        chk("c4_alu_op", 32'(a_alu_op), 32'd0);
        chk("c4_pc_a", a_pc, 32'd4);
        chk("c4_pc_b_wrap", b_pc, 32'h0);
        chk("c4_im_req", 32'(a_im_req), 32'd1);
        repeat (4) tick();
        chk("i2_pc_a", a_pc, 32'd8);
        chk("i2_pc_b", b_pc, 32'd4);
        chk("i2_reg_write", 32'(a_reg_write), 32'd1);

        opcode = 6'h3F;
        tick(); tick();
        chk("halt_done", 32'(a_done), 32'd1);
        chk("halt_busy", 32'(a_busy), 32'd0);
        chk("halt_pc", a_pc, 32'd8);
        chk("halt_cnt", a_cnt, RET2);
        chk("halt_err", 32'(a_err), 32'd0);
        start = 1'b1; tick(); tick(); start = 1'b0;
        chk("halt_sticky", 32'(a_done), 32'd1);
        chk("halt_no_req", 32'(a_im_req), 32'd0);
        chk("halt_pc_hold", a_pc, 32'd8);

        // Instruction memory stall in FETCH
        do_rst();
        im_ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
        chk("st_im_req0", 32'(a_im_req), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_im_req", 32'(a_im_req), 32'd1);
            chk("st_quiet", {29'd0, a_ir_load, a_alu_en, a_reg_write}, 32'd0);
        end
        im_ready = 1'b1; tick(); im_ready = 1'b0;
        chk("st_ir_load", 32'(a_ir_load), 32'd1);
        chk("st_im_req_off", 32'(a_im_req), 32'd0);
        tick();
        chk("st_ir_load_once", 32'(a_ir_load), 32'd0);

        // Illegal opcode after one instruction
        do_rst();
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        opcode = 6'h23;
        tick(); tick();
        chk("err_flag", 32'(a_err), 32'd1);
        chk("err_busy", 32'(a_busy), 32'd0);
        chk("err_pc", a_pc, 32'd4);
        chk("err_rw", 32'(a_reg_write), 32'd0);
        start = 1'b1; repeat (3) tick(); start = 1'b0;
        chk("err_sticky", 32'(a_err), 32'd1);
        chk("err_no_req", 32'(a_im_req), 32'd0);
        chk("err_pc_hold", a_pc, 32'd4);
        chk("err_no_alu", 32'(a_alu_en), 32'd0);
        do_rst();
        chk("err_cleared", 32'(a_err), 32'd0);

        // Reset while in WB
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("wb_alu_en", 32'(a_alu_en), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("wbr_rw", 32'(a_reg_write), 32'd0);
        chk("wbr_pc_a", a_pc, 32'h0);
        chk("wbr_pc_b", b_pc, 32'hFFFF_FFFC);
        chk("wbr_busy", 32'(a_busy), 32'd0);
        chk("wbr_cnt", a_cnt, 32'h0);
        tick();
        chk("wbr_idle", 32'(a_im_req), 32'd0);
        chk("wbr_rw2", 32'(a_reg_write), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
